// File: rtl/int_disp_sched_pkg.sv
// rtl/int_disp_sched_pkg.sv - int-core dispatch constants, types and order-check macro
// Defaults for the int dispatch scheduler live beside the dispQue width they must match.
`ifndef ORDER_CHECK
`define ORDER_CHECK(clk_, en_, vec_) \
  always_ff @(posedge clk_) if (en_) assert ((((vec_) >> 1) & ~(vec_)) == '0) \
    else $error("dispatch valid vector is not a contiguous prefix");
`endif

package int_disp_sched_pkg;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int INTDQ_DISP_WID = 4;
  localparam int INT_IQ_NUM     = 3;
  localparam int INT_IQ_DEPTH   = 8;
  localparam int INT_IQ_ENQ_WID = 2;
  localparam int INT_IQID_W     = clog2_min1(INT_IQ_NUM);

  typedef logic [INT_IQID_W-1:0] iqIdx_t;

endpackage

// File: rtl/int_disp_sched_if.sv
// rtl/int_disp_sched_if.sv - dispQue head / issue-queue credit bundle of the int scheduler
interface int_disp_sched_if
  import int_disp_sched_pkg::*;
#(
  parameter int DISP_WID   = INTDQ_DISP_WID,
  parameter int IQ_NUM     = INT_IQ_NUM,
  parameter int IQ_DEPTH   = INT_IQ_DEPTH,
  parameter int IQ_ENQ_WID = INT_IQ_ENQ_WID
);
  localparam int IQID_W = clog2_min1(IQ_NUM);
  localparam int CRD_W  = clog2_min1(IQ_DEPTH + 1);
  localparam int PORT_W = clog2_min1(IQ_ENQ_WID);
  localparam int FREE_W = clog2_min1(IQ_ENQ_WID + 1);

  logic                              i_squash_vld;
  logic [DISP_WID-1:0]               i_dq_vld;
  logic [DISP_WID-1:0][IQID_W-1:0]   i_dq_iqid;
  logic [DISP_WID-1:0]               o_dq_deq;
  logic [DISP_WID-1:0][PORT_W-1:0]   o_slot_port;
  logic [IQ_NUM-1:0][FREE_W-1:0]     i_iq_free_cnt;
  logic [IQ_NUM-1:0][CRD_W-1:0]      o_iq_credit;
  logic                              o_blocked;

  modport slave (
    input  i_squash_vld, i_dq_vld, i_dq_iqid, i_iq_free_cnt,
    output o_dq_deq, o_slot_port, o_iq_credit, o_blocked
  );

  modport master (
    output i_squash_vld, i_dq_vld, i_dq_iqid, i_iq_free_cnt,
    input  o_dq_deq, o_slot_port, o_iq_credit, o_blocked
  );

endinterface

// File: rtl/int_disp_sched_iq_credit_cnt.sv
// rtl/int_disp_sched_iq_credit_cnt.sv - free-entry credit counter of one int issue queue
module int_disp_sched_iq_credit_cnt #(
  parameter int IQ_DEPTH = 8,
  parameter int CRD_W    = 4,
  parameter int CNT_W    = 3,
  parameter int FREE_W   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic [CNT_W-1:0]  gnt_cnt_i,
  input  logic [FREE_W-1:0] free_cnt_i,
  output logic [CRD_W-1:0]  credit_o
);
  logic [CRD_W-1:0] credit_q, credit_d;
  logic [CRD_W:0]   sum;

  // One extra bit so an over-return or over-grant shows up as out of range instead of wrapping.
  assign sum = {1'b0, credit_q} - (CRD_W+1)'(gnt_cnt_i) + (CRD_W+1)'(free_cnt_i);

  always_comb begin
    credit_d = sum[CRD_W-1:0];
    if (flush_i) credit_d = CRD_W'(IQ_DEPTH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) credit_q <= CRD_W'(IQ_DEPTH);
    else        credit_q <= credit_d;
  end

  always_ff @(posedge clk) begin
    if (rst_n && !flush_i)
      assert (32'(sum) <= IQ_DEPTH)
        else $error("issue queue credit out of range: %0d", sum);
  end

  assign credit_o = credit_q;

endmodule

// File: rtl/int_disp_sched.sv
// rtl/int_disp_sched.sv - in-order credit-based scheduler from int dispQue heads to int issue queues
module int_disp_sched
  import int_disp_sched_pkg::*;
#(
  parameter int DISP_WID   = INTDQ_DISP_WID,
  parameter int IQ_NUM     = INT_IQ_NUM,
  parameter int IQ_DEPTH   = INT_IQ_DEPTH,
  parameter int IQ_ENQ_WID = INT_IQ_ENQ_WID
) (
  input  logic            clk,
  input  logic            rst,
  int_disp_sched_if.slave bus
);
  localparam int IQID_W   = clog2_min1(IQ_NUM);
  localparam int CRD_W    = clog2_min1(IQ_DEPTH + 1);
  localparam int PORT_W   = clog2_min1(IQ_ENQ_WID);
  localparam int FREE_W   = clog2_min1(IQ_ENQ_WID + 1);
  localparam int CNT_W    = clog2_min1(DISP_WID + 1);
  localparam int IQ_SLOTS = 1 << IQID_W;

  logic [IQ_NUM-1:0][CRD_W-1:0]     credit;
  logic [CRD_W-1:0]                 crd_ext  [IQ_SLOTS];
  logic [CNT_W-1:0]                 same_cnt [IQ_SLOTS];
  logic [DISP_WID-1:0]              gnt;
  logic [DISP_WID-1:0][PORT_W-1:0]  port;
  logic                             grant_en;
  logic                             blocked_q, blocked_d;

  assign grant_en = rst & ~bus.i_squash_vld;

  // Unused iqid encodings read as zero credit so they can never be granted.
  for (genvar q = 0; q < IQ_SLOTS; q++) begin : g_ext
    if (q < IQ_NUM) begin : g_real
      assign crd_ext[q] = credit[q];
    end else begin : g_none
      assign crd_ext[q] = '0;
    end
  end

  always_comb begin
    logic             in_order;
    logic [IQID_W-1:0] qi;
    gnt      = '0;
    port     = '0;
    in_order = grant_en;
    qi       = '0;
    for (int q = 0; q < IQ_SLOTS; q++) same_cnt[q] = '0;
    for (int i = 0; i < DISP_WID; i++) begin
      qi = bus.i_dq_iqid[i];
      if (in_order && bus.i_dq_vld[i] && (32'(qi) < IQ_NUM) &&
          (32'(same_cnt[qi]) < 32'(crd_ext[qi])) &&
          (32'(same_cnt[qi]) < IQ_ENQ_WID)) begin
        gnt[i]       = 1'b1;
        port[i]      = PORT_W'(same_cnt[qi]);
        same_cnt[qi] = same_cnt[qi] + CNT_W'(1);
      end else begin
        in_order = 1'b0;
      end
    end
  end

  for (genvar q = 0; q < IQ_NUM; q++) begin : g_crd
    int_disp_sched_iq_credit_cnt #(
      .IQ_DEPTH (IQ_DEPTH),
      .CRD_W    (CRD_W),
      .CNT_W    (CNT_W),
      .FREE_W   (FREE_W)
    ) u_crd (
      .clk        (clk),
      .rst_n      (rst),
      .flush_i    (bus.i_squash_vld),
      .gnt_cnt_i  (same_cnt[q]),
      .free_cnt_i (bus.i_iq_free_cnt[q]),
      .credit_o   (credit[q])
    );
  end

  assign blocked_d = bus.i_squash_vld ? 1'b0 : |(bus.i_dq_vld & ~gnt);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) blocked_q <= 1'b0;
    else      blocked_q <= blocked_d;
  end

  assign bus.o_dq_deq    = gnt;
  assign bus.o_slot_port = port;
  assign bus.o_iq_credit = credit;
  assign bus.o_blocked   = blocked_q;

  `ORDER_CHECK(clk, rst, bus.i_dq_vld)

  always_ff @(posedge clk) begin
    for (int i = 0; i < DISP_WID; i++)
      if (rst && bus.i_dq_vld[i])
        assert (32'(bus.i_dq_iqid[i]) < IQ_NUM)
          else $warning("slot %0d targets nonexistent issue queue %0d", i, bus.i_dq_iqid[i]);
  end

endmodule

// File: tb/tb_int_disp_sched.sv
// tb/tb_int_disp_sched.sv - scoreboard bench for int_disp_sched with hand-computed vectors
module tb_int_disp_sched;
  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  int_disp_sched_if bus ();

  int_disp_sched dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    string      name;
    logic [3:0] deq;
    logic [3:0] port;
    logic [11:0] crd;
    logic       blk;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic cmp(input string nm, input string fld, input logic [11:0] act, input logic [11:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s.%s: got 0x%0h, expected 0x%0h", nm, fld, act, expv);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      e = sb.pop_front();
      cmp(e.name, "deq",    12'(bus.o_dq_deq), 12'(e.deq));
      cmp(e.name, "port",   12'(bus.o_slot_port & e.deq), 12'(e.port));
      cmp(e.name, "credit", 12'(bus.o_iq_credit), e.crd);
      cmp(e.name, "blocked", 12'(bus.o_blocked), 12'(e.blk));
    end
  end

  task automatic drive(input logic sq, input logic [3:0] vld,
                       input int q0, input int q1, input int q2, input int q3,
                       input int f0, input int f1, input int f2);
    bus.i_squash_vld     = sq;
    bus.i_dq_vld         = vld;
    bus.i_dq_iqid[0]     = 2'(q0);
    bus.i_dq_iqid[1]     = 2'(q1);
    bus.i_dq_iqid[2]     = 2'(q2);
    bus.i_dq_iqid[3]     = 2'(q3);
    bus.i_iq_free_cnt[0] = 2'(f0);
    bus.i_iq_free_cnt[1] = 2'(f1);
    bus.i_iq_free_cnt[2] = 2'(f2);
  endtask

  task automatic expect_now(input string nm, input logic [3:0] edeq, input logic [3:0] eport,
                            input int c0, input int c1, input int c2, input logic eblk);
    exp_t x;
    x.name = nm;
    x.deq  = edeq;
    x.port = eport;
    x.crd  = {4'(c2), 4'(c1), 4'(c0)};
    x.blk  = eblk;
    sb.push_back(x);
  endtask

  task automatic cyc(input string nm, input logic sq, input logic [3:0] vld,
                     input int q0, input int q1, input int q2, input int q3,
                     input int f0, input int f1, input int f2,
                     input logic [3:0] edeq, input logic [3:0] eport,
                     input int c0, input int c1, input int c2, input logic eblk);
    @(posedge clk); #1;
    drive(sq, vld, q0, q1, q2, q3, f0, f1, f2);
    expect_now(nm, edeq, eport, c0, c1, c2, eblk);
  endtask

  initial begin
    drive(0, 4'b1111, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    expect_now("reset", 4'b0000, 4'b0000, 8, 8, 8, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    expect_now("first", 4'b0011, 4'b0010, 8, 8, 8, 0);
    //   name       sq vld      iqid 0..3   free 0..2  deq      port     credits  blk
    cyc("mix8",     0, 4'b1111, 0, 1, 0, 2, 0, 0, 0, 4'b1111, 4'b0100, 6, 8, 8, 1);
    cyc("drain1a",  0, 4'b1111, 1, 1, 1, 1, 0, 0, 0, 4'b0011, 4'b0010, 4, 7, 7, 0);
    cyc("drain1b",  0, 4'b1111, 1, 1, 1, 1, 0, 0, 0, 4'b0011, 4'b0010, 4, 5, 7, 1);
    cyc("drain1c",  0, 4'b1111, 1, 1, 1, 1, 0, 0, 0, 4'b0011, 4'b0010, 4, 3, 7, 1);
    cyc("drain1d",  0, 4'b1111, 1, 1, 1, 1, 0, 0, 0, 4'b0001, 4'b0000, 4, 1, 7, 1);
    cyc("c1zero",   0, 4'b1111, 0, 1, 0, 2, 0, 1, 0, 4'b0001, 4'b0000, 4, 0, 7, 1);
    cyc("c1free",   0, 4'b1111, 0, 1, 0, 2, 0, 0, 0, 4'b1111, 4'b0100, 3, 1, 7, 1);
    cyc("drain2a",  0, 4'b1111, 2, 2, 2, 2, 0, 0, 0, 4'b0011, 4'b0010, 1, 0, 6, 0);
    cyc("one2",     0, 4'b0001, 2, 0, 0, 0, 0, 0, 0, 4'b0001, 4'b0000, 1, 0, 4, 1);
    cyc("gntfree2", 0, 4'b0001, 2, 0, 0, 0, 0, 0, 2, 4'b0001, 4'b0000, 1, 0, 3, 0);
    cyc("drain2b",  0, 4'b0011, 2, 2, 0, 0, 0, 0, 0, 4'b0011, 4'b0010, 1, 0, 4, 0);
    cyc("drain2c",  0, 4'b0011, 2, 2, 0, 0, 0, 0, 0, 4'b0011, 4'b0010, 1, 0, 2, 0);
    cyc("c2zero",   0, 4'b0001, 2, 0, 0, 0, 0, 0, 2, 4'b0000, 4'b0000, 1, 0, 0, 0);
    cyc("squash",   1, 4'b1111, 0, 1, 0, 2, 1, 1, 1, 4'b0000, 4'b0000, 1, 0, 2, 1);
    cyc("postsq",   0, 4'b1111, 0, 0, 0, 0, 0, 0, 0, 4'b0011, 4'b0010, 8, 8, 8, 0);
    @(posedge clk); #1;
    drive(0, 4'b1111, 0, 0, 0, 0, 0, 0, 0);
    #2 rst = 1'b0;
    #1 expect_now("async_rst", 4'b0000, 4'b0000, 8, 8, 8, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    drive(0, 4'b0001, 3, 0, 0, 0, 0, 0, 0);
    expect_now("badid", 4'b0000, 4'b0000, 8, 8, 8, 0);
    cyc("badid2",   0, 4'b0001, 3, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 8, 8, 8, 1);
    @(posedge clk); #1;
    drive(0, 4'b0000, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    if (sb.size() != 0) begin
      n_bad += sb.size();
      $display("FAIL scoreboard: %0d entries left unchecked, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
